// File: rtl/mul_seq_ctrl_if.sv
// Handshake between the execute stage (master) and the multiply sequencer (slave).
// The product_hi signal exists only when MUL_HI_EN is defined.
interface mul_seq_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             execute;
    logic [2:0]       alu_ctrl;
    logic             flush;
    logic [WIDTH-1:0] multiplier;
    logic [WIDTH-1:0] multiplicand;
    logic             stall;
    logic             busy;
    logic             result_valid;
    logic [WIDTH-1:0] product;
`ifdef MUL_HI_EN
    logic [WIDTH-1:0] product_hi;

    modport master (
        output execute, alu_ctrl, flush, multiplier, multiplicand,
        input  stall, busy, result_valid, product, product_hi
    );

    modport slave (
        input  execute, alu_ctrl, flush, multiplier, multiplicand,
        output stall, busy, result_valid, product, product_hi
    );
`else
    modport master (
        output execute, alu_ctrl, flush, multiplier, multiplicand,
        input  stall, busy, result_valid, product
    );

    modport slave (
        input  execute, alu_ctrl, flush, multiplier, multiplicand,
        output stall, busy, result_valid, product
    );
`endif
endinterface

// File: rtl/mul_seq_ctrl.sv
// Radix-2 shift-add multiply sequencer that stalls the pipeline for WIDTH+1 cycles.
// Optional feature macro MUL_HI_EN keeps the full 2*WIDTH accumulator and drives product_hi.
module mul_seq_ctrl #(
    parameter int         WIDTH  = 32,
    parameter logic [2:0] MUL_OP = 3'b001
) (
    input  logic          clk,
    input  logic          rst_n,
    mul_seq_ctrl_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
`ifdef MUL_HI_EN
    localparam int AW = 2 * WIDTH;
`else
    // Only the low product half is visible, so the upper half is never built.
    localparam int AW = WIDTH;
`endif

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [AW-1:0]    acc;
    logic [AW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    count;
    logic             start;
    logic             accept;
    logic             last_iter;

    assign start     = bus.execute && (bus.alu_ctrl == MUL_OP);
    assign accept    = start && !bus.flush;
    assign last_iter = (count == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (bus.flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_next = BUSY;
                BUSY:    if (last_iter) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.stall        = 1'b0;
        bus.busy         = (state == BUSY);
        bus.result_valid = (state == DONE);
        bus.product      = '0;
`ifdef MUL_HI_EN
        bus.product_hi   = '0;
`endif
        if (!bus.flush) begin
            bus.stall = ((state == IDLE) && start) || (state == BUSY);
        end
        if (state == DONE) begin
            bus.product    = acc[WIDTH-1:0];
`ifdef MUL_HI_EN
            bus.product_hi = acc[AW-1:WIDTH];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
        end else if (bus.flush) begin
            acc   <= '0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc    <= '0;
                        count  <= '0;
                        mcand  <= AW'(bus.multiplicand);
                        mplier <= bus.multiplier;
                    end
                end
                BUSY: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule
